// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the run-time loadable instruction ROM of the
// openmips SOPC: bus widths, enable levels and the loader state encoding.
package inst_rom_loader_pkg;

   localparam int LOAD_HDR_W    = 16;
   localparam int LOADER_BYTE_W = 8;
   localparam int INST_W        = 32;
   localparam int INST_ADDR_W   = 32;

   typedef logic [LOAD_HDR_W-1:0]    load_hdr_t;     // LoadHdrBus
   typedef logic [LOADER_BYTE_W-1:0] loader_byte_t;  // LoaderByteBus
   typedef logic [INST_W-1:0]        inst_t;         // InstBus
   typedef logic [INST_ADDR_W-1:0]   inst_addr_t;    // InstAddrBus

   localparam logic CHIP_ENABLE = 1'b1;
   // Level that holds the openmips core in reset (the core's rst is active-high).
   localparam logic RST_ENABLE  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_HI = 3'd1,
      ST_HDR_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } loader_state_t;

   // Memory depth in words, one bit wider than the header so 2**16 still fits.
   function automatic logic [LOAD_HDR_W:0] depth_words(input int addr_w);
      return (LOAD_HDR_W+1)'(1) << addr_w;
   endfunction

endpackage

// File: rtl/inst_loader_ram.sv
// Instruction store: one synchronous write port for the loader and one
// asynchronous read port feeding the core's fetch path. Contents are never reset.
module inst_loader_ram
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  inst_t             wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output inst_t             rdata_o
);

   inst_t r_mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Run-time loadable instruction ROM for openmips: parses a byte stream
// (16-bit word count, then big-endian words) and holds the core in reset until done.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start_i,
   input  logic          load_valid_i,
   input  loader_byte_t  load_byte_i,
   output logic          load_ready_o,
   output logic          cpu_rst_o,
   output logic          done_o,
   output logic          err_o,
   input  logic          ce_i,
   input  inst_addr_t    addr_i,
   output inst_t         inst_o,
   output loader_state_t dbg_state_o
);

   // Handshake: a byte moves on a rising edge where load_valid_i && load_ready_o;
   // load_ready_o is registered and never depends on load_valid_i.

   loader_state_t     r_state;
   load_hdr_t         r_cnt;
   logic [ADDR_W-1:0] r_waddr;
   logic [1:0]        r_bidx;
   logic [23:0]       r_asm;
   logic              r_load_ready;
   logic              r_cpu_rst;
   logic              r_done;
   logic              r_err;

   loader_state_t     w_state_nxt;
   logic              w_accept;
   load_hdr_t         w_cnt_full;
   logic              w_last_word;
   logic              w_we;
   inst_t             w_wdata;
   inst_t             w_rdata;
   logic              w_rd_hit;
   logic              w_unused_addr_lsb;

   assign w_accept    = load_valid_i & r_load_ready;
   assign w_cnt_full  = {r_cnt[15:8], load_byte_i};
   assign w_last_word = ({{(LOAD_HDR_W+1-ADDR_W){1'b0}}, r_waddr}
                         == ({1'b0, r_cnt} - (LOAD_HDR_W+1)'(1)));
   // A byte arriving together with a restart is dropped, so it must not write.
   assign w_we        = (r_state == ST_DATA) & w_accept & ~load_start_i & (r_bidx == 2'd3);
   assign w_wdata     = {r_asm, load_byte_i};

   always_comb begin
      w_state_nxt = r_state;
      if (load_start_i) begin
         w_state_nxt = ST_HDR_HI;
      end else if (w_accept) begin
         case (r_state)
            ST_HDR_HI: w_state_nxt = ST_HDR_LO;
            ST_HDR_LO: begin
               if (w_cnt_full == '0) begin
                  w_state_nxt = ST_DONE;
               end else if ({1'b0, w_cnt_full} > depth_words(ADDR_W)) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               if ((r_bidx == 2'd3) && w_last_word) begin
                  w_state_nxt = ST_DONE;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_waddr      <= '0;
         r_bidx       <= '0;
         r_asm        <= '0;
         r_load_ready <= 1'b0;
         r_cpu_rst    <= RST_ENABLE;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_load_ready <= (w_state_nxt == ST_HDR_HI) || (w_state_nxt == ST_HDR_LO)
                         || (w_state_nxt == ST_DATA);
         r_cpu_rst    <= (w_state_nxt != ST_DONE) ? RST_ENABLE : ~RST_ENABLE;
         r_done       <= (w_state_nxt == ST_DONE);
         r_err        <= (w_state_nxt == ST_ERR);
         if (load_start_i) begin
            r_cnt   <= '0;
            r_waddr <= '0;
            r_bidx  <= '0;
         end else if (w_accept) begin
            case (r_state)
               ST_HDR_HI: r_cnt[15:8] <= load_byte_i;
               ST_HDR_LO: begin
                  r_cnt[7:0] <= load_byte_i;
                  r_waddr    <= '0;
                  r_bidx     <= '0;
               end
               ST_DATA: begin
                  r_asm  <= {r_asm[15:0], load_byte_i};
                  r_bidx <= r_bidx + 2'd1;
                  if (r_bidx == 2'd3) begin
                     r_waddr <= r_waddr + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   inst_loader_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_we),
      .waddr_i (r_waddr),
      .wdata_i (w_wdata),
      .raddr_i (addr_i[ADDR_W+1:2]),
      .rdata_o (w_rdata)
   );

   // Only a complete image is ever visible; anything else fetches zero.
   assign w_rd_hit          = (ce_i == CHIP_ENABLE) && r_done && (addr_i[31:ADDR_W+2] == '0);
   assign inst_o            = w_rd_hit ? w_rdata : '0;
   assign w_unused_addr_lsb = ^addr_i[1:0];

   assign load_ready_o = r_load_ready;
   assign cpu_rst_o    = r_cpu_rst;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed-plus-random bench for inst_rom_loader against a byte-stream image model.
module tb_inst_rom_loader;
   import inst_rom_loader_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic [7:0]    load_byte = 8'h00;
   logic          load_ready_o;
   logic          cpu_rst_o;
   logic          done_o;
   logic          err_o;
   logic          ce = 1'b0;
   logic [31:0]   addr = 32'h0;
   logic [31:0]   inst_o;
   loader_state_t dbg_state;

   int            vectors = 0;
   int            miscompares = 0;
   logic [31:0]   mem_m [DEPTH];
   logic          model_done = 1'b0;
   logic          model_err = 1'b0;
   logic          gaps_en = 1'b0;
   logic [7:0]    img [$];

   inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start_i (load_start),
      .load_valid_i (load_valid),
      .load_byte_i  (load_byte),
      .load_ready_o (load_ready_o),
      .cpu_rst_o    (cpu_rst_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .ce_i         (ce),
      .addr_i       (addr),
      .inst_o       (inst_o),
      .dbg_state_o  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic e_done, input logic e_err,
                               input logic e_ready);
      check({tag, "_done"},    32'(done_o),       32'(e_done));
      check({tag, "_err"},     32'(err_o),        32'(e_err));
      check({tag, "_cpu_rst"}, 32'(cpu_rst_o),    32'(!e_done));
      check({tag, "_ready"},   32'(load_ready_o), 32'(e_ready));
   endtask

   // Expected fetch result: visible only once a whole image is in, and only in range.
   task automatic check_inst(input string tag, input logic [31:0] a);
      logic [31:0] exp;
      ce   = 1'b1;
      addr = a;
      #1;
      exp = (model_done && (a[31:ADDR_W+2] == '0)) ? mem_m[a[ADDR_W+1:2]] : 32'h0;
      check(tag, inst_o, exp);
   endtask

   // Image semantics: header count, then complete big-endian words fill memory from 0.
   function automatic void model_session(input logic [7:0] q[$]);
      int n;
      model_done = 1'b0;
      model_err  = 1'b0;
      if (q.size() < 2) return;
      n = {q[0], q[1]};
      if (n > DEPTH) begin
         model_err = 1'b1;
         return;
      end
      for (int w = 0; w < n; w++) begin
         if (2 + 4*w + 3 < q.size())
            mem_m[w] = {q[2+4*w], q[3+4*w], q[4+4*w], q[5+4*w]};
      end
      model_done = (q.size() >= 2 + 4*n);
   endfunction

   task automatic push_word(input logic [31:0] w);
      img.push_back(w[31:24]);
      img.push_back(w[23:16]);
      img.push_back(w[15:8]);
      img.push_back(w[7:0]);
   endtask

   // Called and returns on a falling edge.
   task automatic pulse_start(input logic with_byte, input logic [7:0] b);
      load_start = 1'b1;
      load_valid = with_byte;
      load_byte  = b;
      @(negedge clk);
      load_start = 1'b0;
      load_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      if (gaps_en && ($urandom_range(0, 2) == 0))
         repeat ($urandom_range(1, 3)) @(negedge clk);
      load_valid = 1'b1;
      load_byte  = b;
      guard = 0;
      while (!load_ready_o && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!load_ready_o) begin
         check("ready_timeout", 32'(load_ready_o), 32'd1);
         load_valid = 1'b0;
         return;
      end
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(img[i]);
   endtask

   initial begin
      logic [7:0] part [$];

      // Reset asserted mid-cycle while a load is in progress.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_start(1'b0, 8'h00);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h12);
      #2 rst = 1'b0;
      #1;
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_status("rst", 1'b0, 1'b0, 1'b0);
      model_done = 1'b0;
      check_inst("rst_inst", 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Two-word image from the bring-up program.
      img = {8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h0A, 8'h34, 8'h02, 8'h00, 8'h14};
      pulse_start(1'b0, 8'h00);
      check_status("start1", 1'b0, 1'b0, 1'b1);
      send_range(0, img.size() - 1);
      model_session(img);
      check_status("two_word", 1'b1, 1'b0, 1'b0);
      check_inst("two_word_a0", 32'h0);
      check_inst("two_word_a4", 32'h4);
      check_inst("two_word_a7_lsb", 32'h7);
      check_inst("two_word_oob", 32'h1000);
      ce = 1'b0;
      #1 check("two_word_ce0", inst_o, 32'h0);

      // Zero-length image completes on its header and writes nothing.
      @(negedge clk);
      img = {8'h00, 8'h00};
      pulse_start(1'b0, 8'h00);
      model_done = 1'b0;
      check_inst("reload_hidden", 32'h0);
      send_range(0, 1);
      model_session(img);
      check_status("zero_cnt", 1'b1, 1'b0, 1'b0);
      check_inst("zero_cnt_a0", 32'h0);
      check_inst("zero_cnt_a4", 32'h4);

      // Header one word beyond the depth is rejected and sticks.
      @(negedge clk);
      img = {8'h04, 8'h01};
      pulse_start(1'b0, 8'h00);
      send_range(0, 1);
      model_session(img);
      check_status("overflow", 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check_status("overflow_sticky", 1'b0, 1'b1, 1'b0);
      check_inst("overflow_inst", 32'h0);

      // Exactly full depth with random words and random valid gaps.
      gaps_en = 1'b1;
      img = {8'h04, 8'h00};
      for (int w = 0; w < DEPTH; w++) push_word($urandom);
      pulse_start(1'b0, 8'h00);
      check_status("err_cleared", 1'b0, 1'b0, 1'b1);
      send_range(0, img.size() - 1);
      model_session(img);
      check_status("full_depth", 1'b1, 1'b0, 1'b0);
      check_inst("full_first", 32'h0);
      check_inst("full_last", 32'((DEPTH - 1) * 4));
      for (int k = 0; k < 16; k++)
         check_inst("full_rand", {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))});

      // Abort a 3-word load after 6 bytes; the byte coinciding with start is dropped.
      @(negedge clk);
      img = {8'h00, 8'h03};
      for (int w = 0; w < 3; w++) push_word($urandom);
      pulse_start(1'b0, 8'h00);
      send_range(0, 5);
      part = img[0:5];
      model_session(part);
      check_status("abort_mid", 1'b0, 1'b0, 1'b1);
      check_inst("abort_hidden", 32'h0);
      pulse_start(1'b1, 8'hEE);
      img = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_range(0, img.size() - 1);
      model_session(img);
      check_status("reload", 1'b1, 1'b0, 1'b0);
      check_inst("reload_a0", 32'h0);
      check("reload_a0_const", inst_o, 32'hAABBCCDD);
      check_inst("reload_keep_a4", 32'h4);
      check_inst("reload_keep_a8", 32'h8);

      // Restart from DONE raises cpu_rst on the registering edge; reset during DATA.
      gaps_en = 1'b0;
      @(negedge clk);
      load_start = 1'b1;
      @(posedge clk);
      #1;
      check("restart_cpu_rst", 32'(cpu_rst_o), 32'd1);
      check("restart_done", 32'(done_o), 32'd0);
      @(negedge clk);
      load_start = 1'b0;
      img = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
      send_range(0, img.size() - 1);
      #2 rst = 1'b0;
      #1;
      model_done = 1'b0;
      check("data_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_status("data_rst", 1'b0, 1'b0, 1'b0);
      check_inst("data_rst_inst", 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Loader is fully usable again after reset.
      gaps_en = 1'b1;
      img = {8'h00, 8'h02};
      push_word($urandom);
      push_word($urandom);
      pulse_start(1'b0, 8'h00);
      send_range(0, img.size() - 1);
      model_session(img);
      check_status("post_rst", 1'b1, 1'b0, 1'b0);
      check_inst("post_rst_a0", 32'h0);
      check_inst("post_rst_a4", 32'h4);
      check_inst("post_rst_keep_a8", 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Upstream instruction source for the `openmips` core: it holds the instruction memory that drives the core's `rom_data_i` from `rom_addr_o`/`rom_ce_o`. It fills that memory from a byte-wide load stream (16-bit word count header, then big-endian instruction words). While a load is in progress or has failed, it holds the core in reset; it releases the core only after a complete, valid image is stored. It replaces the fixed `$readmemh` ROM in the SOPC so programs can be loaded at run time.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is `2**ADDR_W` 32-bit words.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-low.
- `load_start_i`  in  1  single-cycle pulse that starts, or restarts, a load session.
- `load_valid_i`  in  1  `load_byte_i` is valid.
- `load_byte_i`  in  8  stream byte.
- `load_ready_o`  out  1  loader accepts a byte this cycle.
- `cpu_rst_o`  out  1  active-high reset to `openmips.rst`.
- `done_o`  out  1  a valid image is loaded and the core is running.
- `err_o`  out  1  the header count exceeded the memory depth (sticky).
- `ce_i`  in  1  from `openmips.rom_ce_o`.
- `addr_i`  in  32  byte address from `openmips.rom_addr_o`.
- `inst_o`  out  32  to `openmips.rom_data_i`.

## Operation
- **Byte transfer:** a byte is accepted on a rising edge where `load_valid_i && load_ready_o`.
- **FSM states:** IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR.
- **IDLE:** `load_start_i` → HDR_HI.
- **HDR_HI:** on an accepted byte, `cnt[15:8] <= byte`; go to HDR_LO.
- **HDR_LO:** on an accepted byte, `cnt[7:0] <= byte`. Then:
  - full count == 0 → DONE;
  - count > `2**ADDR_W` → ERR;
  - otherwise → DATA, with `waddr <= 0` and `bidx <= 0`.
- **DATA:** each accepted byte is shifted into a 24-bit assembly buffer and `bidx` increments.
  - On the 4th byte, write `mem[waddr] <= {b0,b1,b2,b3}`; b0 is the first byte and lands in `[31:24]`.
  - `bidx` wraps to 0 and `waddr` increments.
  - If `waddr == cnt-1` at that write → DONE.
- **DONE:** the session is complete.
- **ERR:** sticky; exits only via `load_start_i` or reset.
- **`load_start_i` in any state except IDLE** (including DONE and ERR): go to HDR_HI and clear `waddr`, `bidx`, `cnt`.
  - A byte accepted in the same cycle is dropped.
  - `load_start_i` has priority over all other transitions.
- **Registered outputs:**
  - `load_ready_o` = state ∈ {HDR_HI, HDR_LO, DATA};
  - `cpu_rst_o` = state ≠ DONE;
  - `done_o` = state == DONE;
  - `err_o` = state == ERR.
- **Read port (combinational):** `inst_o = mem[addr_i[ADDR_W+1:2]]` when `ce_i` is 1, state is DONE, and `addr_i[31:ADDR_W+2] == 0`; otherwise `inst_o = 0`. `addr_i[1:0]` is ignored.
- **Memory:** contents are not reset. Words beyond `cnt` keep their previous contents.

## Timing
- **Reset values:** state IDLE, `load_ready_o` 0, `cpu_rst_o` 1, `done_o` 0, `err_o` 0, `inst_o` 0.
- **Reset mid-load:** returns to IDLE immediately (asynchronous); the partial image is never exposed.
- **Start to first byte:** `load_ready_o` rises on the edge after the `load_start_i` cycle, so the first byte can be accepted in the next cycle.
- **Throughput:** one byte per cycle with no bubbles. Gaps in `load_valid_i` simply stall the FSM.
- **Release:** the last data byte is written, state becomes DONE, and `cpu_rst_o` falls, all on the same edge. The core fetches from PC 0 on the following edge and sees the written data.
- **Reload from DONE:** `cpu_rst_o` rises on the edge that registers `load_start_i`.

## Structure
- **Shared constants** go in the `defines.v` set: state encodings (3-bit), `LoadHdrBus` [15:0], and `LoaderByteBus` [7:0].
- **Existing defines reused:** `InstBus`, `InstAddrBus`, `ChipEnable`, `RstEnable`.
- **Sub-module `inst_loader_ram`:** a `2**ADDR_W`×32 array with one synchronous write port and one asynchronous read port.
- **Top-level logic:** the FSM, counters and assembly buffer live in `inst_rom_loader`.

## Test plan
- **Reset:** `rst` = 0 mid-cycle → all outputs at reset values; `inst_o` = 0 for `addr_i` = 0, `ce_i` = 1.
- **Two-word load:** start, then bytes 00 02 34 01 00 0A 34 02 00 14 →
  - `done_o` = 1 and `cpu_rst_o` = 0 after the 10th byte;
  - `addr_i` 0 → `0x3401000A`; `addr_i` 4 → `0x34020014`; `addr_i` 0x1000 → 0.
- **Zero count:** start, bytes 00 00 → DONE after the 2nd byte; no memory write.
- **Overflow:** `ADDR_W` = 10, header 04 01 → `err_o` = 1, `cpu_rst_o` = 1, `load_ready_o` = 0. A new start clears `err_o`.
- **Abort and backpressure:**
  - random `load_valid_i` gaps, then `load_start_i` after 6 bytes of a 3-word image;
  - reload with 00 01 AA BB CC DD → `mem[0]` = `0xAABBCCDD`, `done_o` = 1;
  - the byte coincident with start is dropped.
- **Reload and reset from DONE:**
  - `load_start_i` in DONE → `cpu_rst_o` = 1 next edge;
  - `rst` low during DATA → IDLE, `inst_o` = 0, `cpu_rst_o` = 1.
